// File: rtl/result_demux.sv
// result_demux: buffered 1-to-2 result router.
// Results enter tagged with a destination select, wait in an in-order FIFO,
// and the head word is offered to exactly one of two consumers. Strict
// order is kept across both outputs, so a stalled head blocks the other
// output (this preserves writeback order).
module result_demux #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [31:0]              out0_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [31:0]              out1_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cnt0,
  output logic [CNT_W-1:0]         cnt1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic        sel;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           head;
  logic             not_empty;
  logic             push;
  logic             pop0;
  logic             pop1;
  logic             pop;

  // Handshake decode and head presentation; depends only on registered
  // state plus the consumer readies, so there is no in->out path.
  always_comb begin
    in_ready   = (level != FULL_LVL);
    not_empty  = (level != '0);
    head       = mem[rd_ptr];
    push       = in_valid && in_ready;
    out0_valid = not_empty && !head.sel;
    out1_valid = not_empty && head.sel;
    out0_data  = not_empty ? head.data : '0;
    out1_data  = not_empty ? head.data : '0;
    pop0       = out0_valid && out0_ready;
    pop1       = out1_valid && out1_ready;
    pop        = pop0 || pop1;
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{sel: in_sel, data: in_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a
  // power of two. Simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Per-output delivery counters; wrap silently at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (pop1) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

endmodule
